// File: rtl/qdr_user_app_responder.sv
// Behavioural stand-in for the QDR controller: calibration delay, BRAM-backed write port,
// and a fixed-latency pipelined read port.
module qdr_user_app_responder #(
    parameter int QDR_DATA_WIDTH   = 36,
    parameter int QDR_ADDR_WIDTH   = 19,
    parameter int QDR_BURST_LENGTH = 4,
    parameter int MEM_DEPTH_LOG2   = 10,
    parameter int RD_LATENCY       = 8,
    parameter int CAL_CYCLES       = 64
) (
    input  logic                                       qdr_clk,
    input  logic                                       rst,
    output logic                                       init_calib_complete,
    input  logic                                       user_app_wr_cmd,
    input  logic [QDR_ADDR_WIDTH-1:0]                  user_app_wr_addr,
    input  logic [QDR_DATA_WIDTH*QDR_BURST_LENGTH-1:0] user_app_wr_data,
    input  logic                                       user_app_rd_cmd,
    input  logic [QDR_ADDR_WIDTH-1:0]                  user_app_rd_addr,
    output logic [QDR_DATA_WIDTH*QDR_BURST_LENGTH-1:0] user_app_rd_data,
    output logic                                       user_app_rd_valid,
    output logic                                       cmd_dropped,
    output logic                                       addr_alias_err,
    output logic [31:0]                                wr_count,
    output logic [31:0]                                rd_count
);
    // state    | meaning
    // CAL_WAIT | counting down calibration delay, commands dropped
    // CAL_DONE | calibrated, commands accepted (terminal until rst)

    localparam int DW    = QDR_DATA_WIDTH * QDR_BURST_LENGTH;
    localparam int DEPTH = 2 ** MEM_DEPTH_LOG2;
    localparam int CW    = $clog2(CAL_CYCLES + 1);

    typedef enum logic {CAL_WAIT, CAL_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cal_cnt, cal_cnt_nxt;

    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            state   <= CAL_WAIT;
            cal_cnt <= CW'(CAL_CYCLES - 1);
        end else begin
            state   <= state_nxt;
            cal_cnt <= cal_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cal_cnt_nxt = cal_cnt;
        case (state)
            CAL_WAIT: begin
                if (cal_cnt == '0) state_nxt = CAL_DONE;
                else               cal_cnt_nxt = cal_cnt - 1'b1;
            end
            default: state_nxt = CAL_DONE;
        endcase
    end

    always_comb begin
        init_calib_complete = (state == CAL_DONE);
    end

    logic wr_in_range, rd_in_range, wr_acc, rd_acc;

    assign wr_in_range = ((user_app_wr_addr >> MEM_DEPTH_LOG2) == '0);
    assign rd_in_range = ((user_app_rd_addr >> MEM_DEPTH_LOG2) == '0);
    assign wr_acc      = user_app_wr_cmd & init_calib_complete & wr_in_range & ~rst;
    assign rd_acc      = user_app_rd_cmd & init_calib_complete;

    // No reset on the array: contents survive rst so data is readable after recalibration.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] ram_q;

    always_ff @(posedge qdr_clk) begin
        if (wr_acc) mem[user_app_wr_addr[MEM_DEPTH_LOG2-1:0]] <= user_app_wr_data;
        ram_q <= mem[user_app_rd_addr[MEM_DEPTH_LOG2-1:0]];
    end

    logic          v0, r0;
    logic          vld [1:RD_LATENCY-1];
    logic [DW-1:0] dat [1:RD_LATENCY-1];

    // Data stages load only on valid beats, so the last stage holds the previous return.
    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            v0 <= 1'b0;
            r0 <= 1'b0;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld[k] <= 1'b0;
                dat[k] <= '0;
            end
        end else begin
            v0     <= rd_acc;
            r0     <= rd_in_range;
            vld[1] <= v0;
            if (v0) dat[1] <= r0 ? ram_q : '0;
            for (int k = 2; k < RD_LATENCY; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) dat[k] <= dat[k-1];
            end
        end
    end

    assign user_app_rd_valid = vld[RD_LATENCY-1];
    assign user_app_rd_data  = dat[RD_LATENCY-1];

    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            cmd_dropped    <= 1'b0;
            addr_alias_err <= 1'b0;
            wr_count       <= '0;
            rd_count       <= '0;
        end else begin
            if ((user_app_wr_cmd | user_app_rd_cmd) & ~init_calib_complete)
                cmd_dropped <= 1'b1;
            if ((user_app_wr_cmd & ~wr_in_range) | (user_app_rd_cmd & ~rd_in_range))
                addr_alias_err <= 1'b1;
            if (wr_acc) wr_count <= wr_count + 32'd1;
            if (rd_acc) rd_count <= rd_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_qdr_user_app_responder.sv
// Directed plus randomized bench for qdr_user_app_responder against a queue-based
// reference model of calibration, memory contents and read return timing.
module tb_qdr_user_app_responder;
    logic         qdr_clk = 1'b0;
    logic         rst;
    logic         init_calib_complete;
    logic         user_app_wr_cmd;
    logic [18:0]  user_app_wr_addr;
    logic [143:0] user_app_wr_data;
    logic         user_app_rd_cmd;
    logic [18:0]  user_app_rd_addr;
    logic [143:0] user_app_rd_data;
    logic         user_app_rd_valid;
    logic         cmd_dropped;
    logic         addr_alias_err;
    logic [31:0]  wr_count;
    logic [31:0]  rd_count;

    qdr_user_app_responder dut (
        .qdr_clk             (qdr_clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .user_app_wr_cmd     (user_app_wr_cmd),
        .user_app_wr_addr    (user_app_wr_addr),
        .user_app_wr_data    (user_app_wr_data),
        .user_app_rd_cmd     (user_app_rd_cmd),
        .user_app_rd_addr    (user_app_rd_addr),
        .user_app_rd_data    (user_app_rd_data),
        .user_app_rd_valid   (user_app_rd_valid),
        .cmd_dropped         (cmd_dropped),
        .addr_alias_err      (addr_alias_err),
        .wr_count            (wr_count),
        .rd_count            (rd_count)
    );

    always #5 qdr_clk = ~qdr_clk;

    int cyc = 0;
    always @(posedge qdr_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int           due;
        logic [143:0] d;
    } rd_t;

    logic [143:0] mmem [0:1023];
    rd_t          q[$];
    int           lowcnt = 0;
    logic [31:0]  m_wr = 0, m_rd = 0;
    logic         m_drop = 0, m_alias = 0;
    logic [143:0] m_last = '0;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] rand144();
        logic [143:0] r = '0;
        for (int i = 0; i < 5; i++) r = {r[111:0], $urandom()};
        return r;
    endfunction

    // Drive one cycle, check outputs at negedge, then advance the model.
    task automatic step(input logic r, input logic w, input logic [18:0] wa,
                        input logic [143:0] wd, input logic rd, input logic [18:0] ra);
        rd_t e;
        logic cal;
        rst = r; user_app_wr_cmd = w; user_app_wr_addr = wa; user_app_wr_data = wd;
        user_app_rd_cmd = rd; user_app_rd_addr = ra;
        @(negedge qdr_clk);
        chk("init_calib_complete", {143'd0, init_calib_complete}, {143'd0, lowcnt >= 64});
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rd_valid_expected", {143'd0, user_app_rd_valid}, 144'd1);
            chk("rd_data", user_app_rd_data, q[0].d);
            m_last = q[0].d;
            void'(q.pop_front());
        end else begin
            chk("rd_valid_idle", {143'd0, user_app_rd_valid}, 144'd0);
            chk("rd_data_hold", user_app_rd_data, m_last);
        end
        chk("cmd_dropped", {143'd0, cmd_dropped}, {143'd0, m_drop});
        chk("addr_alias_err", {143'd0, addr_alias_err}, {143'd0, m_alias});
        chk("wr_count", {112'd0, wr_count}, {112'd0, m_wr});
        chk("rd_count", {112'd0, rd_count}, {112'd0, m_rd});
        if (r) begin
            q.delete();
            m_wr = 0; m_rd = 0; m_drop = 0; m_alias = 0; m_last = '0; lowcnt = 0;
        end else begin
            cal = (lowcnt >= 64);
            if ((w || rd) && !cal) m_drop = 1;
            if ((w && wa >= 1024) || (rd && ra >= 1024)) m_alias = 1;
            if (cal && rd) begin
                m_rd++;
                e.due = cyc + 8;
                e.d   = (ra < 1024) ? mmem[ra[9:0]] : '0;
                q.push_back(e);
            end
            if (cal && w && wa < 1024) begin
                mmem[wa[9:0]] = wd;
                m_wr++;
            end
            lowcnt++;
        end
        @(posedge qdr_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0);
    endtask

    task automatic wr(input logic [18:0] a, input logic [143:0] d);
        step(0, 1, a, d, 0, '0);
    endtask

    task automatic rd(input logic [18:0] a);
        step(0, 0, '0, '0, 1, a);
    endtask

    initial begin
        logic [18:0]  wa, ra;
        logic [143:0] a5;
        a5 = {36{4'hA, 4'h5}} ;
        rst = 1; user_app_wr_cmd = 0; user_app_wr_addr = '0; user_app_wr_data = '0;
        user_app_rd_cmd = 0; user_app_rd_addr = '0;
        @(posedge qdr_clk);
        #1;

        // reset, then calibration with commands issued while still calibrating
        for (int i = 0; i < 4; i++) step(1, 0, '0, '0, 0, '0);
        idle(10);
        step(0, 1, 19'd3, rand144(), 1, 19'd3);
        idle(5);
        rd(19'd4);
        idle(66);

        // single write/read of the A5 pattern
        wr(19'd5, a5);
        rd(19'd5);
        idle(10);

        // back-to-back reads of addresses 0..15
        for (int i = 0; i < 16; i++) wr(19'(i), 144'(i));
        for (int i = 0; i < 16; i++) rd(19'(i));
        idle(10);

        // read-before-write on same address
        wr(19'd7, 144'd1);
        step(0, 1, 19'd7, 144'd2, 1, 19'd7);
        rd(19'd7);
        idle(10);

        // out-of-range write and read
        wr(19'd0, rand144());
        step(0, 1, 19'h40000, rand144(), 1, 19'h40000);
        rd(19'd0);
        idle(10);

        // randomized traffic over a preloaded window
        for (int i = 16; i < 32; i++) wr(19'(i), rand144());
        for (int i = 0; i < 150; i++) begin
            wa = 19'($urandom_range(0, 31));
            ra = 19'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) wa = wa | 19'h40000;
            if ($urandom_range(0, 9) == 0) ra = ra | 19'h40000;
            step(0, 1'($urandom_range(0, 1)), wa, rand144(), 1'($urandom_range(0, 1)), ra);
        end
        idle(10);

        // reset with reads in flight; memory survives recalibration
        for (int i = 0; i < 4; i++) rd(19'(i));
        idle(2);
        step(1, 1, 19'd1, rand144(), 1, 19'd2);
        step(1, 0, '0, '0, 0, '0);
        idle(70);
        for (int i = 0; i < 4; i++) rd(19'(i));
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
